// File: rtl/compare_operand_loader_if.sv
//-----------------------------------------------------------------------------
// compare_operand_loader_if
//
// Bundles the operand-loader bus: the shared switch bus, the three raw
// buttons, and the held operand pair going to the magnitude comparator.
//
//   master : drives din/load/swap/clear, observes a_out/b_out/valid/state
//   slave  : the loader itself (inverse directions)
//
// Parameter: WIDTH - operand width in bits.
//-----------------------------------------------------------------------------
interface compare_operand_loader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             swap;
  logic             clear;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             valid;
  logic [1:0]       state;

  modport master (
    output din, load, swap, clear,
    input  a_out, b_out, valid, state
  );

  modport slave (
    input  din, load, swap, clear,
    output a_out, b_out, valid, state
  );
endinterface

// File: rtl/compare_operand_loader.sv
//-----------------------------------------------------------------------------
// compare_operand_loader
//
// Operand stage in front of the 4-bit magnitude comparator. Two operands are
// captured one after the other from the shared switch bus with the load
// button and held on a_out/b_out; valid flags a complete pair. swap exchanges
// a complete pair, clear empties the stage.
//
// Ports:
//   clk        system clock, all state on its rising edge
//   rst        asynchronous, active-high reset
//   bus.din    switch bus, sampled on a load capture
//   bus.load   raw button (asynchronous)
//   bus.swap   raw button (asynchronous)
//   bus.clear  raw button (asynchronous)
//   bus.a_out  held operand A
//   bus.b_out  held operand B
//   bus.valid  high when a_out/b_out form a complete pair
//   bus.state  FSM state: 00 WAIT_A, 01 WAIT_B, 10 VALID
//
// Build option: define COMPARE_LOADER_DEBOUNCE_EN to insert a per-button
// debounce stage (DEBOUNCE_CYCLES stable cycles, must be >= 2) between the
// synchronizer and the edge detector. Without it, a press sampled first at
// edge k updates the registers at edge k+2; with it, at edge
// k+2+DEBOUNCE_CYCLES.
//-----------------------------------------------------------------------------
module compare_operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                     clk,
  input logic                     rst,
  compare_operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    VALID  = 2'b10
  } state_t;

  // Button bit positions inside the conditioning vectors.
  localparam int BTN_LOAD  = 0;
  localparam int BTN_SWAP  = 1;
  localparam int BTN_CLEAR = 2;

  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] level;   // conditioned button level fed to the edge detector
  logic [2:0] prev;
  logic [2:0] pulse;

  assign btn_raw = {bus.clear, bus.swap, bus.load};

  // Two-flop synchronizer for the asynchronous buttons.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbour; '=' here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef COMPARE_LOADER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       db_level;

  // The debounced level only follows sync2 after it has disagreed for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  // NOTE: the counter array is a handful of flops, not a RAM, so every
  // element is cleared by the asynchronous reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      db_level <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db_level[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            db_level[i] <= ~db_level[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  // Rising-edge detect: one pulse per press, none on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

  // Operand FSM: state register plus next-state/datapath logic.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  // Priority clear > load > swap; lower-priority pulses in the same cycle are
  // simply dropped.
  // NOTE: every signal is given its hold value first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;

    if (pulse[BTN_CLEAR]) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (pulse[BTN_LOAD]) begin
            a_d     = bus.din;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (pulse[BTN_LOAD]) begin
            b_d     = bus.din;
            state_d = VALID;
          end
        end
        VALID: begin
          if (pulse[BTN_LOAD]) begin
            // A fresh A starts a new pair; the old B is kept until replaced.
            a_d     = bus.din;
            state_d = WAIT_B;
          end else if (pulse[BTN_SWAP]) begin
            a_d = b_q;
            b_d = a_q;
          end
        end
        default: begin
          // Illegal encoding 11: recover to an empty stage.
          state_d = WAIT_A;
          a_d     = '0;
          b_d     = '0;
        end
      endcase
    end
  end

  // valid is registered alongside state so it is a clean flop output and
  // tracks state == VALID exactly.
  assign valid_d = (state_d == VALID);

  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.valid = valid_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_compare_operand_loader.sv
//-----------------------------------------------------------------------------
// tb_compare_operand_loader
//
// Directed sequence followed by randomized button presses, each checked
// against a behavioural model of the operand pair (A, B, phase). Works for
// both builds; the capture latency follows COMPARE_LOADER_DEBOUNCE_EN.
//-----------------------------------------------------------------------------
module tb_compare_operand_loader;

  localparam int WIDTH = 4;
`ifdef COMPARE_LOADER_DEBOUNCE_EN
  localparam int LAT = 2 + 16;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  compare_operand_loader_if #(.WIDTH(WIDTH)) bus ();

  compare_operand_loader #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: the pair and how far loading has progressed
  // (0 = nothing, 1 = A held, 2 = complete pair).
  logic [3:0] m_a = 4'h0;
  logic [3:0] m_b = 4'h0;
  int         m_phase = 0;

  function automatic void model_reset();
    m_a = 4'h0;
    m_b = 4'h0;
    m_phase = 0;
  endfunction

  // mask bits: [0] load, [1] swap, [2] clear
  function automatic void model_apply(input logic [2:0] mask, input logic [3:0] d);
    logic [3:0] t;
    if (mask[2]) begin
      model_reset();
    end else if (mask[0]) begin
      if (m_phase == 1) begin
        m_b = d;
        m_phase = 2;
      end else begin
        m_a = d;
        m_phase = 1;
      end
    end else if (mask[1] && m_phase == 2) begin
      t   = m_a;
      m_a = m_b;
      m_b = t;
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input int ephase);
    check({tag, "/a_out"}, 8'(bus.a_out), 8'(ea));
    check({tag, "/b_out"}, 8'(bus.b_out), 8'(eb));
    check({tag, "/valid"}, 8'(bus.valid), 8'(ephase == 2));
    check({tag, "/state"}, 8'(bus.state), 8'(ephase));
  endtask

  task automatic release_buttons();
    bus.load  = 1'b0;
    bus.swap  = 1'b0;
    bus.clear = 1'b0;
  endtask

  // Press the buttons in mask with din=d, hold for 'hold' cycles, then
  // release. Checks the value one edge before and exactly at the capture edge.
  task automatic press(input logic [2:0] mask, input logic [3:0] d, input int hold,
                       input string tag);
    logic [3:0] oa, ob;
    int         oph;
    oa  = m_a;
    ob  = m_b;
    oph = m_phase;
    @(posedge clk);
    #2;
    bus.din = d;
    {bus.clear, bus.swap, bus.load} = mask;
    model_apply(mask, d);
    @(posedge clk);                     // edge k: first sample of the press
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check_all({tag, "/before"}, oa, ob, oph);
    @(posedge clk);                     // edge k+LAT: capture
    @(negedge clk);
    check_all({tag, "/after"}, m_a, m_b, m_phase);
    bus.din = 4'($urandom);             // din is free to move after capture
    repeat (hold - LAT - 1) @(posedge clk);
    #2;
    release_buttons();
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    check_all({tag, "/release"}, m_a, m_b, m_phase);
  endtask

  initial begin
    int         pick;
    logic [2:0] mask;

    bus.din = 4'h0;
    release_buttons();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("in_reset", 4'h0, 4'h0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("post_reset", 4'h0, 4'h0, 0);

    // Load a pair 5 / 9
    press(3'b001, 4'h5, LAT + 2, "load_5");
    press(3'b001, 4'h9, LAT + 2, "load_9");

    // Swap the complete pair, then start a new one with 3
    press(3'b010, 4'h0, LAT + 2, "swap");
    press(3'b001, 4'h3, LAT + 2, "load_3");

    // Held load gives exactly one capture, then a re-press completes the pair
    press(3'b100, 4'h0, LAT + 2, "clear1");
    press(3'b001, 4'hA, 50, "hold_A");
    press(3'b001, 4'hC, LAT + 2, "load_C");

    // load and clear together in VALID: clear wins
    press(3'b100, 4'h0, LAT + 2, "clear2");
    press(3'b001, 4'h7, LAT + 2, "load_7");
    press(3'b001, 4'h2, LAT + 2, "load_2");
    press(3'b101, 4'hE, LAT + 2, "load_clear");

    // swap in WAIT_B is ignored
    press(3'b001, 4'h4, LAT + 2, "load_4");
    press(3'b010, 4'h0, LAT + 2, "swap_waitb");

    // Asynchronous reset in the middle of a pair
    press(3'b100, 4'h0, LAT + 2, "clear3");
    press(3'b001, 4'h6, LAT + 2, "load_6");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", 4'h0, 4'h0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("rst_release", 4'h0, 4'h0, 0);
    press(3'b001, 4'hB, LAT + 2, "load_after_rst");

`ifdef COMPARE_LOADER_DEBOUNCE_EN
    // A 5-cycle glitch must be filtered out
    @(posedge clk);
    #2;
    bus.din  = 4'hD;
    bus.load = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    bus.load = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_all("glitch", m_a, m_b, m_phase);
    // A 20-cycle press lands at edge k+18
    press(3'b001, 4'hF, 20, "db_press_F");
`endif

    // Randomized presses, occasionally several buttons at once
    for (int i = 0; i < 30; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 5)      mask = 3'b001;
      else if (pick < 7) mask = 3'b010;
      else if (pick < 8) mask = 3'b100;
      else               mask = 3'($urandom_range(1, 7));
      press(mask, 4'($urandom), LAT + 2 + $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/compare_operand_loader.md
Name: compare_operand_loader

Overview:
- Upstream operand stage for the 4-bit magnitude comparator.
- Two operands share one switch bus `din`. They are captured one after the other with a `load` button and held stable on `a_out`/`b_out`. A `valid` flag tells the comparator output stage when both operands are present.
- Button inputs are synchronized and edge-detected inside the block. Operands can also be swapped or cleared.

Parameters:
- WIDTH, 4, operand width in bits (matches comparator A/B).
- DEBOUNCE_CYCLES, 16, stable-cycle count for debounce. Used only with DEBOUNCE_EN; must be ≥2.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  switch bus; sampled on a load capture.
- load  input  1  raw button, asynchronous to clk.
- swap  input  1  raw button, asynchronous to clk.
- clear  input  1  raw button, asynchronous to clk.
- a_out  output  WIDTH  held operand A, drives comparator A.
- b_out  output  WIDTH  held operand B, drives comparator B.
- valid  output  1  high when a_out/b_out form a complete pair.
- state  output  2  FSM state: 00 WAIT_A, 01 WAIT_B, 10 VALID.

Behaviour:
- Reset (async, rst=1):
  - a_out=0, b_out=0, valid=0, state=WAIT_A.
  - All synchronizer, edge-detect and debounce flops cleared.
  - Reset mid-sequence discards any partially loaded operand.
- Input conditioning:
  - Each of load, swap and clear passes through a 2-flop synchronizer.
  - Edge detect uses a third flop holding the previous synchronized level.
  - pulse = sync2 & ~prev, one cycle wide per press.
  - A button held high produces exactly one pulse. Release produces none.
- Latency: if the first rising edge that samples a button high is edge k, the register update for that press occurs at edge k+2. Outputs show the new value in the cycle after edge k+2.
- Pulse priority in the same cycle: clear > load > swap. Lower-priority pulses in that cycle are dropped, not queued.
- clear pulse, any state: a_out=0, b_out=0, valid=0, next state WAIT_A.
- load pulse:
  - WAIT_A: a_out<=din; next WAIT_B; valid stays 0.
  - WAIT_B: b_out<=din; next VALID; valid<=1 on the same edge.
  - VALID: a_out<=din; b_out keeps its old value; valid<=0; next WAIT_B. This starts a new pair.
- swap pulse:
  - VALID: a_out<=b_out and b_out<=a_out in one edge; stays VALID with valid=1.
  - WAIT_A or WAIT_B: ignored, no state change.
- No pulse: all registers hold.
- Invariants:
  - valid==1 iff state==VALID.
  - state never takes the value 11. If it does (illegal encoding), the next edge goes to WAIT_A with both operands cleared.
- Width: din is captured verbatim with no arithmetic. a_out/b_out change only on the capture edges listed above; between captures they are glitch-free register outputs.
- din may change at any time. Only its value at the capture edge matters.

Optional Feature:
- Macro: COMPARE_LOADER_DEBOUNCE_EN.
- Defined:
  - A per-button debounce stage sits between sync2 and the edge detector, with a counter sized for DEBOUNCE_CYCLES.
  - The counter increments each cycle sync2 differs from the debounced level and resets to 0 when they are equal.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, the debounced level toggles on that edge and the counter returns to 0.
  - Edge detect operates on the debounced level. Capture for a press first sampled at edge k occurs at edge k+2+DEBOUNCE_CYCLES.
  - A bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- Undefined: no debounce logic; latency is k+2 as above.

Test Plan:
- Reset, then din=4'h5, load press; din=4'h9, load press → a_out=5, b_out=9, valid=1, state=10. Each capture lands exactly 2 edges after the first sampling edge.
- Continuing from the previous pair, swap press → a_out=9, b_out=5, valid stays 1. Then din=4'h3, load → a_out=3, b_out=5, valid=0, state=01.
- load held high for 50 cycles in WAIT_A with din=4'hA → exactly one capture: a_out=A, state=01. Release and re-press with din=4'hC → b_out=C, valid=1.
- load and clear synchronized pulses in the same cycle while in VALID (a=7, b=2) → a_out=0, b_out=0, valid=0, state=00. swap pressed in WAIT_B → no change.
- Assert rst for 1 cycle mid-load (state=01, a_out=6), asynchronously between clock edges → outputs go to 0/00 immediately without waiting for a clock edge. The next load captures into a_out.
- With COMPARE_LOADER_DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - A load glitch 5 cycles high → no capture.
  - A 20-cycle press with din=4'hF → a_out=F at edge k+18.
